// File: rtl/fp_mult_pkg.sv
// Shared constants and state encoding for the floating-point multiplier datapath.
package fp_mult_pkg;

  localparam int unsigned MW    = 11;
  localparam int unsigned PW    = 2 * MW;
  localparam int unsigned CNT_W = $clog2(MW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mant_shift_add_ctrl_cla.sv
// 22-bit carry-lookahead adder: 4-bit lookahead groups rippling group carries,
// with a final 2-bit group. Purely combinational; clk only times the input check.
module carryLookAhead (
  input  logic        clk,
  input  logic [21:0] a,
  input  logic [21:0] b,
  input  logic        cin,
  output logic [21:0] s,
  output logic        co
);

  localparam int unsigned NG = 5;

  logic [21:0] g;
  logic [21:0] p;
  logic [22:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int k = 0; k < NG; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
    // Trailing 2-bit group covering bits 21:20.
    c[21] = g[20] | (p[20] & c[20]);
    c[22] = g[21] | (p[21] & g[20]) | (p[21] & p[20] & c[20]);
  end

  assign s  = p ^ c[21:0];
  assign co = c[22];

  a_cin_known: assert property (@(posedge clk) !$isunknown(cin));

endmodule

// File: rtl/mant_shift_add_ctrl.sv
// Sequential shift-and-add mantissa multiplier: accepts two MW-bit mantissas,
// iterates MW cycles through one shared adder, returns the PW-bit raw product.
module mant_shift_add_ctrl #(
  parameter int unsigned MW = 11,
  parameter int unsigned PW = 22
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] a,
  input  logic [MW-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] product,
  output logic          busy
);

  import fp_mult_pkg::*;

  state_e            state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [MW-1:0]     mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     product_q, product_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic [PW-1:0]     sum;
  logic              sum_co;

  // Shared adder: acc + mcand every RUN cycle, committed only when the multiplier bit is set.
  carryLookAhead u_cla (
    .clk (clk),
    .a   (acc_q),
    .b   (mcand_q),
    .cin (1'b0),
    .s   (sum),
    .co  (sum_co)
  );

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          mcand_d  = PW'(a);
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MW - 1)) begin
          product_d   = acc_d;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags follow the next state so they stay pure register outputs.
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = busy_q;

  a_ready_valid_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(in_ready_q && out_valid_q));

  // Partial sums are bounded by a*2^(cnt+1), so a carry-out in RUN means a datapath bug.
  a_no_carry_in_run: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == RUN) |-> !sum_co);

endmodule

// File: tb/tb_mant_shift_add_ctrl.sv
// Randomised scoreboard bench for mant_shift_add_ctrl; expected products come from a*b.
module tb_mant_shift_add_ctrl;

  localparam int unsigned MW  = 11;
  localparam int unsigned PW  = 22;
  localparam int          LAT = 11;
  localparam int          II  = 13;

  typedef struct {
    logic [PW-1:0] p;
    int            c;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] a_i;
  logic [MW-1:0] b_i;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          busy;

  exp_t sb[$];
  int   hist[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  mant_shift_add_ctrl #(.MW(MW), .PW(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: every accepted operand pair yields a*b after LAT edges.
  task automatic issue_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && in_valid && in_ready) begin
        e.p = PW'(a_i) * PW'(b_i);
        e.c = cyc + 1;
        sb.push_back(e);
        hist.push_back(cyc + 1);
      end
    end
  endtask

  task automatic monitor_loop();
    exp_t cur;
    bit   active = 1'b0;
    cur.p = '0;
    cur.c = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
      end else begin
        check("ready_valid_exclusive", 32'(in_ready & out_valid), 32'd0);
        if (out_valid) begin
          if (!active) begin
            check("output_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
              cur = sb.pop_front();
              check("product", 32'(product), 32'(cur.p));
              check("latency_sb", 32'(cyc - cur.c), 32'(LAT));
            end
            active = 1'b1;
          end else begin
            check("product_stable", 32'(product), 32'(cur.p));
          end
          check("busy_in_done", 32'(busy), 32'd1);
          if (out_ready) active = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_accept(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      tick();
    end
  endtask

  task automatic run_op(input logic [MW-1:0] x, input logic [MW-1:0] y);
    bit got;
    int n;
    a_i = x;
    b_i = y;
    in_valid = 1'b1;
    wait_accept(got);
    in_valid = 1'b0;
    check("accepted", 32'(got), 32'd1);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("latency", 32'(n), 32'(LAT));
  endtask

  function automatic logic [MW-1:0] pick_operand();
    logic [MW-1:0] v;
    case ($urandom % 8)
      0:       v = '0;
      1:       v = 11'h7FF;
      2:       v = 11'h400;
      default: v = MW'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    bit got;
    bit saw;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_i       = '0;
    b_i       = '0;

    fork
      issue_loop();
      monitor_loop();
    join_none

    // Reset held with random inputs.
    repeat (3) begin
      a_i       = MW'($urandom);
      b_i       = MW'($urandom);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_product", 32'(product), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    tick();
    check("in_ready_after_reset", 32'(in_ready), 32'd1);
    check("busy_after_reset", 32'(busy), 32'd0);

    // Directed boundary operands.
    run_op(11'h400, 11'h400);
    check("one_times_one", 32'(product), 32'h100000);
    tick();
    run_op(11'h7FF, 11'h7FF);
    check("max_operands", 32'(product), 32'h3FF001);
    tick();
    run_op(11'h000, 11'h7FF);
    check("zero_operand", 32'(product), 32'h0);
    tick();

    // Backpressure: result must hold while new operands are offered.
    out_ready = 1'b0;
    run_op(11'h005, 11'h003);
    repeat (5) begin
      in_valid = 1'b1;
      a_i      = MW'($urandom);
      b_i      = MW'($urandom);
      tick();
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_product", 32'(product), 32'h00000F);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_in_ready_release", 32'(in_ready), 32'd1);
    check("bp_out_valid_release", 32'(out_valid), 32'd0);

    // Reset in the middle of RUN aborts the operation.
    a_i      = 11'h7FF;
    b_i      = 11'h7FF;
    in_valid = 1'b1;
    wait_accept(got);
    in_valid = 1'b0;
    check("abort_accepted", 32'(got), 32'd1);
    repeat (4) tick();
    check("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_in_ready_after", 32'(in_ready), 32'd1);
    saw = 1'b0;
    repeat (15) begin
      tick();
      if (out_valid) saw = 1'b1;
    end
    check("abort_no_output", 32'(saw), 32'd0);
    run_op(11'h003, 11'h005);
    check("after_abort_product", 32'(product), 32'h00000F);
    tick();

    // Back-to-back with out_ready high: initiation interval.
    hist.delete();
    in_valid = 1'b1;
    repeat (45) begin
      a_i = pick_operand();
      b_i = pick_operand();
      tick();
    end
    in_valid = 1'b0;
    repeat (15) tick();
    check("ii_count", 32'(hist.size()), 32'd4);
    for (int i = 1; i < hist.size(); i++) begin
      check("ii_interval", 32'(hist[i] - hist[i-1]), 32'(II));
    end

    // Random traffic with random backpressure.
    repeat (400) begin
      in_valid  = 1'($urandom);
      a_i       = pick_operand();
      b_i       = pick_operand();
      out_ready = 1'(($urandom % 4) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (30) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
